// File: rtl/factor_judge.sv
// Judge/HP stage: divides the running remainder by the selected prime with a
// 16-cycle restoring divider, runs the per-question timer and tracks hit points.
module factor_judge #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIME_LIMIT = 10,
  parameter int HP_INIT    = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  STATE,
  input  logic [2:0]  SEL,
  input  logic        DEC,
  input  logic [15:0] Q_VAL,
  output logic [1:0]  JUDG_OUT,
  output logic [1:0]  WRONG_OUT,
  output logic [1:0]  HP_OUT,
  output logic [15:0] REMAIN,
  output logic        BUSY,
  output logic [3:0]  TIME_LEFT,
  output logic [1:0]  PLAYER_HP,
  output logic [1:0]  ENEMY_HP
);

  localparam logic [3:0] ST_READY    = 4'd2;
  localparam logic [3:0] ST_QUESTION = 4'd3;
  localparam logic [3:0] ST_INPUT    = 4'd4;
  localparam logic [3:0] ST_WRONG    = 4'd7;
  localparam logic [3:0] ST_GOOD     = 4'd8;
  localparam logic [3:0] ST_OUCH     = 4'd9;
  localparam logic [3:0] ST_WIN      = 4'd10;
  localparam logic [3:0] ST_LOSE     = 4'd11;

  localparam int             PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [3:0]     T_INIT   = 4'(TIME_LIMIT);
  localparam logic [1:0]     HP_FULL  = 2'(HP_INIT);

  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_COMMIT} div_state_t;

  div_state_t    div_state, div_next;
  logic [3:0]    state_d;
  logic          dec_d;
  logic          load_one;
  logic [PW-1:0] prescaler;
  logic [4:0]    divisor;
  logic [4:0]    prime_sel;
  logic [4:0]    acc;
  logic [15:0]   dvd;
  logic [3:0]    div_cnt;
  logic [5:0]    trial;
  logic          trial_ge;

  logic load, in_play, start, commit_en, count_en, tick, solved_now, timeout_now;

  assign load      = (state_d == ST_QUESTION) && (STATE == ST_INPUT);
  assign in_play   = (STATE == ST_INPUT) || (STATE == ST_WRONG);
  assign start     = (div_state == DIV_IDLE) && DEC && !dec_d && (STATE == ST_INPUT)
                     && (JUDG_OUT == 2'b00) && (WRONG_OUT == 2'b00) && !load;
  assign commit_en = (div_state == DIV_COMMIT) && in_play && !load;
  assign count_en  = (STATE == ST_INPUT) && (JUDG_OUT == 2'b00) && !load;
  assign tick      = count_en && (prescaler == PRE_LAST);

  // A question of 1 is already solved; it is reported the cycle after load.
  assign solved_now  = (commit_en && (acc == 5'd0) && (dvd == 16'd1)) || load_one;
  assign timeout_now = tick && (TIME_LEFT <= 4'd1);

  assign trial    = {acc, dvd[15]};
  assign trial_ge = trial >= {1'b0, divisor};
  assign BUSY     = (div_state == DIV_RUN);

  always_comb begin
    prime_sel = 5'd2;
    case (SEL)
      3'd0: prime_sel = 5'd2;
      3'd1: prime_sel = 5'd3;
      3'd2: prime_sel = 5'd5;
      3'd3: prime_sel = 5'd7;
      3'd4: prime_sel = 5'd11;
      3'd5: prime_sel = 5'd13;
      3'd6: prime_sel = 5'd17;
      3'd7: prime_sel = 5'd19;
      default: prime_sel = 5'd2;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) div_state <= DIV_IDLE;
    else     div_state <= div_next;
  end

  // Leaving INPUT/WRONG or a fresh load drops any division without committing.
  always_comb begin
    div_next = div_state;
    case (div_state)
      DIV_IDLE:   if (start) div_next = DIV_RUN;
      DIV_RUN:    if (div_cnt == 4'd15) div_next = DIV_COMMIT;
      DIV_COMMIT: div_next = DIV_IDLE;
      default:    div_next = DIV_IDLE;
    endcase
    if (load || !in_play) div_next = DIV_IDLE;
  end

  // Restoring divider: quotient bits shift into dvd as the dividend shifts out.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc     <= 5'd0;
      dvd     <= 16'd0;
      div_cnt <= 4'd0;
      divisor <= 5'd2;
    end else if (start) begin
      acc     <= 5'd0;
      dvd     <= REMAIN;
      div_cnt <= 4'd0;
      divisor <= prime_sel;
    end else if (div_state == DIV_RUN) begin
      acc     <= trial_ge ? 5'(trial - {1'b0, divisor}) : trial[4:0];
      dvd     <= {dvd[14:0], trial_ge};
      div_cnt <= div_cnt + 4'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_d   <= ST_READY;
      dec_d     <= 1'b0;
      load_one  <= 1'b0;
      REMAIN    <= 16'd0;
      WRONG_OUT <= 2'b00;
      JUDG_OUT  <= 2'b00;
    end else begin
      state_d  <= STATE;
      dec_d    <= DEC;
      load_one <= load && (Q_VAL == 16'd1);

      if (load)                              REMAIN <= Q_VAL;
      else if (commit_en && (acc == 5'd0))   REMAIN <= dvd;

      if (load || (STATE == ST_WRONG))       WRONG_OUT <= 2'b00;
      else if (commit_en && (acc != 5'd0))   WRONG_OUT <= 2'b11;

      if (load || (STATE == ST_READY))       JUDG_OUT <= 2'b00;
      else if (JUDG_OUT == 2'b00)            JUDG_OUT <= {timeout_now, solved_now};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prescaler <= '0;
      TIME_LEFT <= T_INIT;
    end else if (load) begin
      prescaler <= '0;
      TIME_LEFT <= T_INIT;
    end else if (count_en) begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick && (TIME_LEFT != 4'd0)) TIME_LEFT <= TIME_LEFT - 4'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PLAYER_HP <= HP_FULL;
      ENEMY_HP  <= HP_FULL;
    end else if (((state_d == ST_WIN) || (state_d == ST_LOSE)) && (STATE == ST_READY)) begin
      PLAYER_HP <= HP_FULL;
      ENEMY_HP  <= HP_FULL;
    end else begin
      if ((STATE == ST_GOOD) && (state_d != ST_GOOD) && (ENEMY_HP != 2'd0))
        ENEMY_HP <= ENEMY_HP - 2'd1;
      if ((STATE == ST_OUCH) && (state_d != ST_OUCH) && (PLAYER_HP != 2'd0))
        PLAYER_HP <= PLAYER_HP - 2'd1;
    end
  end

  assign HP_OUT = (ENEMY_HP == 2'd0)  ? 2'b01 :
                  (PLAYER_HP == 2'd0) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_factor_judge.sv
// Bench for factor_judge: a long-timer instance for division checks and a
// short-timer instance for timeout behaviour, both driven by the same inputs.
module tb_factor_judge;

  localparam logic [3:0] ST_READY    = 4'd2;
  localparam logic [3:0] ST_QUESTION = 4'd3;
  localparam logic [3:0] ST_INPUT    = 4'd4;
  localparam logic [3:0] ST_DRAW     = 4'd6;
  localparam logic [3:0] ST_WRONG    = 4'd7;
  localparam logic [3:0] ST_GOOD     = 4'd8;
  localparam logic [3:0] ST_OUCH     = 4'd9;
  localparam logic [3:0] ST_WIN      = 4'd10;
  localparam logic [3:0] ST_LOSE     = 4'd11;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  STATE;
  logic [2:0]  SEL;
  logic        DEC;
  logic [15:0] Q_VAL;

  logic [1:0]  m_judg, m_wrong, m_hp, m_php, m_ehp;
  logic [15:0] m_remain;
  logic        m_busy;
  logic [3:0]  m_time;
  logic [1:0]  f_judg, f_wrong, f_hp, f_php, f_ehp;
  logic [15:0] f_remain;
  logic        f_busy;
  logic [3:0]  f_time;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int primes[8] = '{2, 3, 5, 7, 11, 13, 17, 19};

  factor_judge #(.CLK_HZ(40), .TIME_LIMIT(15), .HP_INIT(3)) u_main (
    .CLK(CLK), .RST(RST), .STATE(STATE), .SEL(SEL), .DEC(DEC), .Q_VAL(Q_VAL),
    .JUDG_OUT(m_judg), .WRONG_OUT(m_wrong), .HP_OUT(m_hp), .REMAIN(m_remain),
    .BUSY(m_busy), .TIME_LEFT(m_time), .PLAYER_HP(m_php), .ENEMY_HP(m_ehp)
  );

  factor_judge #(.CLK_HZ(10), .TIME_LIMIT(2), .HP_INIT(3)) u_fast (
    .CLK(CLK), .RST(RST), .STATE(STATE), .SEL(SEL), .DEC(DEC), .Q_VAL(Q_VAL),
    .JUDG_OUT(f_judg), .WRONG_OUT(f_wrong), .HP_OUT(f_hp), .REMAIN(f_remain),
    .BUSY(f_busy), .TIME_LEFT(f_time), .PLAYER_HP(f_php), .ENEMY_HP(f_ehp)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] q;
    logic [2:0]  sel;
    logic [15:0] rem;
    logic [1:0]  wrong;
    logic [1:0]  judg;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // READY -> QUESTION -> INPUT; returns just after the load edge with Q_VAL scrambled
  task automatic do_question(input logic [15:0] q);
    STATE = ST_READY;
    tick();
    STATE = ST_QUESTION;
    Q_VAL = q;
    tick();
    STATE = ST_INPUT;
    tick();
    Q_VAL = 16'hBEEF;
  endtask

  // One DEC rising edge, then wait until the commit has landed
  task automatic apply_stimulus(input logic [2:0] sel);
    SEL = sel;
    DEC = 1'b1;
    tick();
    DEC = 1'b0;
    repeat (17) tick();
  endtask

  initial begin
    vecs[0]  = '{16'd12,    3'd0, 16'd6,     2'b00, 2'b00};
    vecs[1]  = '{16'd15,    3'd0, 16'd15,    2'b11, 2'b00};
    vecs[2]  = '{16'd15,    3'd1, 16'd5,     2'b00, 2'b00};
    vecs[3]  = '{16'd2,     3'd0, 16'd1,     2'b00, 2'b01};
    vecs[4]  = '{16'd0,     3'd3, 16'd0,     2'b00, 2'b00};
    vecs[5]  = '{16'd65535, 3'd1, 16'd21845, 2'b00, 2'b00};
    vecs[6]  = '{16'd65534, 3'd0, 16'd32767, 2'b00, 2'b00};
    vecs[7]  = '{16'd361,   3'd7, 16'd19,    2'b00, 2'b00};
    vecs[8]  = '{16'd13,    3'd5, 16'd1,     2'b00, 2'b01};
    vecs[9]  = '{16'd17,    3'd6, 16'd1,     2'b00, 2'b01};
    vecs[10] = '{16'd11,    3'd3, 16'd11,    2'b11, 2'b00};
    vecs[11] = '{16'd65521, 3'd7, 16'd65521, 2'b11, 2'b00};

    RST = 1'b1; STATE = ST_READY; SEL = 3'd0; DEC = 1'b0; Q_VAL = 16'd0;
    repeat (2) tick();
    check_output("rst_judg", m_judg, 0);
    check_output("rst_wrong", m_wrong, 0);
    check_output("rst_remain", m_remain, 0);
    check_output("rst_busy", m_busy, 0);
    check_output("rst_time_main", m_time, 15);
    check_output("rst_time_fast", f_time, 2);
    check_output("rst_php", m_php, 3);
    check_output("rst_ehp", m_ehp, 3);
    check_output("rst_hp_out", m_hp, 0);
    RST = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      do_question(vecs[i].q);
      apply_stimulus(vecs[i].sel);
      check_output($sformatf("vec%0d_remain", i), m_remain, vecs[i].rem);
      check_output($sformatf("vec%0d_wrong", i), m_wrong, vecs[i].wrong);
      check_output($sformatf("vec%0d_judg", i), m_judg, vecs[i].judg);
    end

    // 12 -> 6 -> 3 -> 1 with BUSY timing and a DEC edge ignored mid-division
    do_question(16'd12);
    SEL = 3'd0; DEC = 1'b1;
    tick();
    DEC = 1'b0;
    check_output("busy_first", m_busy, 1);
    repeat (4) tick();
    SEL = 3'd1; DEC = 1'b1;
    tick();
    DEC = 1'b0;
    repeat (10) tick();
    check_output("busy_last", m_busy, 1);
    check_output("remain_pre_commit", m_remain, 12);
    tick();
    check_output("busy_commit", m_busy, 0);
    check_output("remain_at_commit", m_remain, 12);
    tick();
    check_output("chain_remain1", m_remain, 6);
    apply_stimulus(3'd0);
    check_output("chain_remain2", m_remain, 3);
    check_output("chain_judg2", m_judg, 0);
    apply_stimulus(3'd1);
    check_output("chain_remain3", m_remain, 1);
    check_output("chain_judg3", m_judg, 1);
    apply_stimulus(3'd0);
    check_output("solved_ignore_remain", m_remain, 1);
    check_output("solved_ignore_wrong", m_wrong, 0);

    // Wrong divisor held until WRONG, no reload on return to INPUT
    do_question(16'd15);
    apply_stimulus(3'd0);
    check_output("wrong_set", m_wrong, 3);
    apply_stimulus(3'd1);
    check_output("wrong_ignore_remain", m_remain, 15);
    STATE = ST_WRONG;
    tick();
    check_output("wrong_cleared", m_wrong, 0);
    STATE = ST_INPUT;
    tick();
    check_output("wrong_no_reload", m_remain, 15);
    apply_stimulus(3'd1);
    check_output("wrong_retry", m_remain, 5);

    // Question of 1 is solved the cycle after load
    do_question(16'd1);
    check_output("one_judg_load", m_judg, 0);
    tick();
    check_output("one_judg_next", m_judg, 1);

    // Short timer: 2 -> 1 -> 0 at 10-cycle intervals
    do_question(16'd7);
    check_output("tmr_load", f_time, 2);
    repeat (9) tick();
    check_output("tmr_before_tick", f_time, 2);
    tick();
    check_output("tmr_tick1", f_time, 1);
    check_output("tmr_judg_mid", f_judg, 0);
    repeat (10) tick();
    check_output("tmr_tick2", f_time, 0);
    check_output("tmr_judg", f_judg, 2);
    repeat (12) tick();
    check_output("tmr_saturate", f_time, 0);
    check_output("tmr_judg_hold", f_judg, 2);

    // Final commit lands on the same edge as the timeout
    do_question(16'd2);
    repeat (2) tick();
    SEL = 3'd0; DEC = 1'b1;
    tick();
    DEC = 1'b0;
    repeat (16) tick();
    check_output("draw_pre_judg", f_judg, 0);
    check_output("draw_pre_time", f_time, 1);
    tick();
    check_output("draw_judg", f_judg, 3);
    check_output("draw_remain", f_remain, 1);
    check_output("draw_time", f_time, 0);
    check_output("draw_main_judg", m_judg, 1);
    STATE = ST_DRAW;
    repeat (2) tick();
    check_output("draw_php", f_php, 3);
    check_output("draw_ehp", f_ehp, 3);

    // Hit points
    STATE = ST_GOOD; repeat (2) tick();
    check_output("good1_ehp", m_ehp, 2);
    STATE = ST_READY; tick(); STATE = ST_GOOD; tick();
    check_output("good2_ehp", m_ehp, 1);
    STATE = ST_READY; tick(); STATE = ST_GOOD; tick();
    check_output("good3_ehp", m_ehp, 0);
    check_output("good3_hp_out", m_hp, 1);
    STATE = ST_READY; tick(); STATE = ST_GOOD; tick();
    check_output("good_sat_ehp", m_ehp, 0);
    STATE = ST_OUCH; tick();
    check_output("ouch1_php", m_php, 2);
    check_output("ouch1_hp_out", m_hp, 1);
    STATE = ST_WIN; tick(); STATE = ST_READY; tick();
    check_output("win_php", m_php, 3);
    check_output("win_ehp", m_ehp, 3);
    check_output("win_hp_out", m_hp, 0);
    for (int k = 0; k < 3; k++) begin
      STATE = ST_OUCH; tick(); STATE = ST_READY; tick();
    end
    check_output("ouch3_php", m_php, 0);
    check_output("ouch3_hp_out", m_hp, 2);
    STATE = ST_LOSE; tick(); STATE = ST_READY; tick();
    check_output("lose_php", m_php, 3);
    STATE = ST_OUCH; tick();
    check_output("pre_rst_php", m_php, 2);

    // Randomised questions checked against the arithmetic model
    for (int qn = 0; qn < 20; qn++) begin
      int v, n, p, d;
      bit solved;
      v = 1;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        p = primes[$urandom_range(0, 7)];
        if (v * p <= 65535) v = v * p;
      end
      do_question(16'(v));
      solved = 0;
      d = 0;
      while (!solved && d < 10) begin
        logic [2:0] sel;
        int exp_wrong;
        if ($urandom_range(0, 2) != 0) begin
          int cand[$];
          for (int k = 0; k < 8; k++) if (v % primes[k] == 0) cand.push_back(k);
          sel = 3'(cand[$urandom_range(0, cand.size() - 1)]);
        end else begin
          sel = 3'($urandom_range(0, 7));
        end
        p = primes[sel];
        if (v % p == 0) begin
          v = v / p;
          exp_wrong = 0;
          solved = (v == 1);
        end else begin
          exp_wrong = 3;
        end
        apply_stimulus(sel);
        check_output($sformatf("rnd%0d_%0d_remain", qn, d), m_remain, v);
        check_output($sformatf("rnd%0d_%0d_wrong", qn, d), m_wrong, exp_wrong);
        check_output($sformatf("rnd%0d_%0d_judg", qn, d), m_judg, solved ? 1 : 0);
        if (exp_wrong != 0) begin
          STATE = ST_WRONG; tick();
          check_output($sformatf("rnd%0d_%0d_wclr", qn, d), m_wrong, 0);
          STATE = ST_INPUT; tick();
        end
        d++;
      end
    end

    // Asynchronous reset in the middle of a division
    do_question(16'd12);
    SEL = 3'd0; DEC = 1'b1;
    tick();
    DEC = 1'b0;
    repeat (7) tick();
    check_output("mid_div_busy", m_busy, 1);
    RST = 1'b1;
    #1;
    check_output("arst_busy", m_busy, 0);
    check_output("arst_remain", m_remain, 0);
    check_output("arst_time_main", m_time, 15);
    check_output("arst_time_fast", f_time, 2);
    check_output("arst_judg", m_judg, 0);
    check_output("arst_wrong", m_wrong, 0);
    check_output("arst_php", m_php, 3);
    check_output("arst_hp_out", m_hp, 0);
    tick();
    RST = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
